// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 raster constants and timing helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int VGA_HVID = 640;
    localparam int VGA_HFP  = 16;
    localparam int VGA_HS   = 96;
    localparam int VGA_HBP  = 48;
    localparam int VGA_VVID = 480;
    localparam int VGA_VFP  = 10;
    localparam int VGA_VS   = 2;
    localparam int VGA_VBP  = 33;

    function automatic int span_total(input int vid, input int fp, input int sw, input int bp);
        return vid + fp + sw + bp;
    endfunction

    // Sync pulse sits after the visible area and the front porch.
    function automatic int sync_start(input int vid, input int fp);
        return vid + fp;
    endfunction

    function automatic logic in_window(input int pos, input int lo, input int len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_delay
// Description : Enabled shift register with async clear for output alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, i_en};
            assign o_q      = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator (pixel-clock domain).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   HVID     = VGA_HVID,
    parameter int   HFP      = VGA_HFP,
    parameter int   HS       = VGA_HS,
    parameter int   HBP      = VGA_HBP,
    parameter int   VVID     = VGA_VVID,
    parameter int   VFP      = VGA_VFP,
    parameter int   VS       = VGA_VS,
    parameter int   VBP      = VGA_VBP,
    parameter logic HPOL     = 1'b0,
    parameter logic VPOL     = 1'b0,
    parameter int   CW       = 10,
    parameter int   FCW      = 8,
    parameter int   PIPE_DLY = 0
) (
    input  logic           clk_25,
    input  logic           rst_n,
    input  logic           en,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [CW-1:0]  pixel_x,
    output logic [CW-1:0]  pixel_y,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt
);

    localparam int c_HTOT  = span_total(HVID, HFP, HS, HBP);
    localparam int c_VTOT  = span_total(VVID, VFP, VS, VBP);
    localparam int c_HS_LO = sync_start(HVID, HFP);
    localparam int c_VS_LO = sync_start(VVID, VFP);

    generate
        if ((c_HTOT - 1) >= (1 << CW)) begin : g_chk_hcw
            $error("vga_timing_gen: HTOT-1 does not fit in CW bits");
        end
        if ((c_VTOT - 1) >= (1 << CW)) begin : g_chk_vcw
            $error("vga_timing_gen: VTOT-1 does not fit in CW bits");
        end
        if ((PIPE_DLY < 0) || (PIPE_DLY > 15)) begin : g_chk_dly
            $error("vga_timing_gen: PIPE_DLY must be within 0..15");
        end
    endgenerate

    localparam logic [CW-1:0] c_H_LAST = CW'(c_HTOT - 1);
    localparam logic [CW-1:0] c_V_LAST = CW'(c_VTOT - 1);

    // One word per pixel position; it travels the delay line as a unit so
    // every output always describes the same coordinate.
    typedef struct packed {
        logic [FCW-1:0] fcnt;
        logic           line_st;
        logic           frame_st;
        logic           hsync;
        logic           vsync;
        logic           de;
        logic [CW-1:0]  x;
        logic [CW-1:0]  y;
    } pix_t;

    localparam pix_t c_RST = '{
        fcnt:     '0,
        line_st:  1'b0,
        frame_st: 1'b0,
        hsync:    ~HPOL,
        vsync:    ~VPOL,
        de:       1'b0,
        x:        '0,
        y:        '0
    };

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic          w_h_wrap;
    logic          w_line_st;
    logic          w_frame_st;
    pix_t          w_s1_d;
    pix_t          r_s1;
    pix_t          w_out;
    logic          r_en_d;

    assign w_h_wrap = (r_h_cnt == c_H_LAST);

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (en) begin
            if (w_h_wrap) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // Frame count is carried with the word so it changes together with frame_start.
    always_comb begin
        w_line_st       = (r_h_cnt == '0);
        w_frame_st      = w_line_st && (r_v_cnt == '0);
        w_s1_d          = c_RST;
        w_s1_d.x        = r_h_cnt;
        w_s1_d.y        = r_v_cnt;
        w_s1_d.line_st  = w_line_st;
        w_s1_d.frame_st = w_frame_st;
        w_s1_d.de       = (int'(r_h_cnt) < HVID) && (int'(r_v_cnt) < VVID);
        w_s1_d.hsync    = sync_level(in_window(int'(r_h_cnt), c_HS_LO, HS), HPOL);
        w_s1_d.vsync    = sync_level(in_window(int'(r_v_cnt), c_VS_LO, VS), VPOL);
        w_s1_d.fcnt     = r_s1.fcnt + FCW'(w_frame_st);
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= c_RST;
        end else if (en) begin
            r_s1 <= w_s1_d;
        end
    end

    vga_sync_delay #(
        .WIDTH   ($bits(pix_t)),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (c_RST)
    ) u_sync_delay (
        .clk   (clk_25),
        .rst_n (rst_n),
        .i_en  (en),
        .i_d   (r_s1),
        .o_q   (w_out)
    );

    // Strobe flags are held with the word while en is low; gating with the
    // previous-cycle enable limits them to the single cycle the word arrived.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_en_d <= 1'b0;
        end else begin
            r_en_d <= en;
        end
    end

    assign hsync       = w_out.hsync;
    assign vsync       = w_out.vsync;
    assign de          = w_out.de;
    assign pixel_x     = w_out.x;
    assign pixel_y     = w_out.y;
    assign frame_cnt   = w_out.fcnt;
    assign line_start  = w_out.line_st  & r_en_d;
    assign frame_start = w_out.frame_st & r_en_d;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench; reduced raster, plain and delayed/inverted DUTs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int T_HVID = 8;
    localparam int T_HFP  = 2;
    localparam int T_HS   = 3;
    localparam int T_HBP  = 2;
    localparam int T_VVID = 4;
    localparam int T_VFP  = 1;
    localparam int T_VS   = 2;
    localparam int T_VBP  = 1;
    localparam int T_HTOT = 15;
    localparam int T_VTOT = 8;
    localparam int FRAME  = T_HTOT * T_VTOT;
    localparam int HS_LO  = 10;
    localparam int VS_LO  = 5;
    localparam int DLY    = 3;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [4:0] x;
        logic [4:0] y;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    logic       clk_25;
    logic       rst_n;
    logic       en;
    logic       hsync_a, vsync_a, de_a, ls_a, fs_a;
    logic [4:0] x_a, y_a;
    logic [7:0] fc_a;
    logic       hsync_b, vsync_b, de_b, ls_b, fs_b;
    logic [4:0] x_b, y_b;
    logic [7:0] fc_b;

    int   total = 0;
    int   bad   = 0;
    int   k     = 0;
    int   cyc   = 0;
    int   last_ls = -1;
    int   last_fs = -1;
    int   hs_low  = 0;
    int   fs_seen = 0;
    int   ls_per, hs_per, fs_per;
    exp_t qa[$];
    exp_t qb[$];

    vga_timing_gen #(
        .HVID(T_HVID), .HFP(T_HFP), .HS(T_HS), .HBP(T_HBP),
        .VVID(T_VVID), .VFP(T_VFP), .VS(T_VS), .VBP(T_VBP),
        .HPOL(1'b0), .VPOL(1'b0), .CW(5), .FCW(8), .PIPE_DLY(0)
    ) dut_a (
        .clk_25(clk_25), .rst_n(rst_n), .en(en),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
        .pixel_x(x_a), .pixel_y(y_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_timing_gen #(
        .HVID(T_HVID), .HFP(T_HFP), .HS(T_HS), .HBP(T_HBP),
        .VVID(T_VVID), .VFP(T_VFP), .VS(T_VS), .VBP(T_VBP),
        .HPOL(1'b1), .VPOL(1'b1), .CW(5), .FCW(8), .PIPE_DLY(DLY)
    ) dut_b (
        .clk_25(clk_25), .rst_n(rst_n), .en(en),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
        .pixel_x(x_b), .pixel_y(y_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    initial clk_25 = 1'b0;
    always #5 clk_25 = ~clk_25;

    // kk = number of enabled edges whose data has reached this output.
    function automatic exp_t model(input int kk, input logic stepped, input logic hpol, input logic vpol);
        exp_t r;
        int   p, xx, yy;
        r = '{hs: ~hpol, vs: ~vpol, de: 1'b0, x: 5'd0, y: 5'd0, ls: 1'b0, fs: 1'b0, fc: 8'd0};
        if (kk > 0) begin
            p    = (kk - 1) % FRAME;
            xx   = p % T_HTOT;
            yy   = p / T_HTOT;
            r.x  = 5'(xx);
            r.y  = 5'(yy);
            r.de = (xx < T_HVID) && (yy < T_VVID);
            r.hs = (xx >= HS_LO && xx < HS_LO + T_HS) ? hpol : ~hpol;
            r.vs = (yy >= VS_LO && yy < VS_LO + T_VS) ? vpol : ~vpol;
            r.fc = 8'((((kk - 1) / FRAME) + 1) % 256);
            r.ls = stepped && (xx == 0);
            r.fs = stepped && (p == 0);
        end
        return r;
    endfunction

    function automatic exp_t obs_a();
        return '{hs: hsync_a, vs: vsync_a, de: de_a, x: x_a, y: y_a, ls: ls_a, fs: fs_a, fc: fc_a};
    endfunction

    function automatic exp_t obs_b();
        return '{hs: hsync_b, vs: vsync_b, de: de_b, x: x_b, y: y_b, ls: ls_b, fs: fs_b, fc: fc_b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic e);
        exp_t ea, eb;
        en = e;
        if (!rst_n) k = 0;
        else if (e) k++;
        qa.push_back(model(k, e && rst_n, 1'b0, 1'b0));
        qb.push_back(model(k - DLY, e && rst_n, 1'b1, 1'b1));
        @(posedge clk_25);
        #1;
        cyc++;
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk($sformatf("A.out k=%0d", k), {9'd0, obs_a()}, {9'd0, ea});
        chk($sformatf("B.out k=%0d", k), {9'd0, obs_b()}, {9'd0, eb});
        if (rst_n) begin
            if (!hsync_a) hs_low++;
            if (ls_a) begin
                if (last_ls >= 0) begin
                    chk("A.ls_period", 32'(cyc - last_ls), 32'(ls_per));
                    chk("A.hs_width", 32'(hs_low), 32'(hs_per));
                end
                last_ls = cyc;
                hs_low  = 0;
            end
            if (fs_a) begin
                fs_seen++;
                chk("A.fc_on_fs", {24'd0, fc_a}, 32'(fs_seen % 256));
                if (last_fs >= 0) chk("A.fs_period", 32'(cyc - last_fs), 32'(fs_per));
                last_fs = cyc;
            end
        end
    endtask

    task automatic new_mode(input int lp, input int hp, input int fp);
        ls_per  = lp;
        hs_per  = hp;
        fs_per  = fp;
        last_ls = -1;
        last_fs = -1;
        hs_low  = 0;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        en    = 1'b0;
        new_mode(T_HTOT, T_HS, FRAME);

        // Reset held with en high: outputs must stay inactive.
        repeat (3) step(1'b1);

        rst_n = 1'b1;
        step(1'b1);
        chk("A.first_pixel", {13'd0, fs_a, de_a, x_a, y_a, fc_a}, {13'd0, 1'b1, 1'b1, 5'd0, 5'd0, 8'd1});

        // Full rate across more than 256 frames to cover the frame counter wrap.
        repeat (2 * FRAME) step(1'b1);
        repeat (255 * FRAME) step(1'b1);

        // Half rate: same sequence, periods doubled, strobes still one cycle.
        new_mode(2 * T_HTOT, 2 * T_HS, 2 * FRAME);
        for (int i = 0; i < 4 * FRAME; i++) step((i % 2) == 0);

        // Run to (5,2) and pull reset between clock edges.
        new_mode(T_HTOT, T_HS, FRAME);
        guard = 0;
        while ((((k - 1) % FRAME) != (2 * T_HTOT + 5)) && (guard < 2 * FRAME)) begin
            step(1'b1);
            guard++;
        end
        chk("A.reach_mid", {22'd0, x_a, y_a}, {22'd0, 5'd5, 5'd2});
        #3;
        rst_n = 1'b0;
        #1;
        chk("A.async_rst", {9'd0, obs_a()}, {9'd0, model(0, 1'b0, 1'b0, 1'b0)});
        chk("B.async_rst", {9'd0, obs_b()}, {9'd0, model(0, 1'b0, 1'b1, 1'b1)});
        k       = 0;
        fs_seen = 0;
        new_mode(T_HTOT, T_HS, FRAME);
        repeat (2) step(1'b1);
        rst_n = 1'b1;
        step(1'b1);
        chk("A.restart", {13'd0, fs_a, de_a, x_a, y_a, fc_a}, {13'd0, 1'b1, 1'b1, 5'd0, 5'd0, 8'd1});
        repeat (FRAME + 20) step(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
